// File: rtl/led_status_blinker.sv
// Purpose : blinks a 4-bit status code on an LED, one blink per unit, timed by heartbeat ticks, then holds a dark gap.
// Latency : a code is accepted in IDLE; the FSM enters ON on the next edge and led_out follows one cycle later.
// Backpressure: code_ready_out is high only in IDLE; a code offered while busy is dropped, not queued.
//
// Ports:
//   clk_in         system clock, rising edge
//   reset_in       asynchronous active-low reset
//   beat_in        heartbeat square wave; each edge of it is one tick
//   code_in        number of blinks to show (0 = show nothing)
//   code_valid_in  code_in is offered this cycle
//   code_ready_out block is idle and will take a code
//   busy_out       blink or gap sequence in progress
//   led_out        registered LED drive, active-high
//
// Optional feature: define LED_PWM_EN to dim the lit LED with a 16-slot PWM
// (PWM_DUTY on-slots out of 16). Without it, the LED is steadily on while lit.
module led_status_blinker #(
    parameter int unsigned GAP_BEATS = 4,
    parameter int unsigned PWM_DUTY  = 8
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic       beat_in,
    input  logic [3:0] code_in,
    input  logic       code_valid_in,
    output logic       code_ready_out,
    output logic       busy_out,
    output logic       led_out
);

    // Elaboration-time parameter range checks.
    if (GAP_BEATS < 1 || GAP_BEATS > 15) begin : g_bad_gap
        $error("GAP_BEATS must be in 1..15");
    end
    if (PWM_DUTY < 1 || PWM_DUTY > 16) begin : g_bad_duty
        $error("PWM_DUTY must be in 1..16");
    end

    localparam logic [3:0] GAP_LOAD = GAP_BEATS[3:0];

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t     state_q;
    logic       beat_q;
    logic [3:0] remaining_q;
    logic [3:0] gap_cnt_q;
    logic       led_q;
    logic       led_d;
    logic       tick;
    logic       led_on;

    // Both edges of the heartbeat count as a tick.
    assign tick   = beat_in ^ beat_q;
    assign led_on = (state_q == ST_ON);

`ifdef LED_PWM_EN
    localparam logic [4:0] DUTY = PWM_DUTY[4:0];

    logic [3:0] pwm_cnt_q;

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            pwm_cnt_q <= 4'd0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 4'd1;
        end
    end

    // Compare in 5 bits so DUTY = 16 keeps the LED on in every slot.
    assign led_d = led_on && ({1'b0, pwm_cnt_q} < DUTY);
`else
    assign led_d = led_on;
`endif

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q     <= ST_IDLE;
            beat_q      <= 1'b0;
            remaining_q <= 4'd0;
            gap_cnt_q   <= 4'd0;
            led_q       <= 1'b0;
        end else begin
            beat_q <= beat_in;
            led_q  <= led_d;
            case (state_q)
                // Ticks in IDLE, including one on the accept cycle, are ignored.
                ST_IDLE: begin
                    if (code_valid_in && (code_in != 4'd0)) begin
                        remaining_q <= code_in;
                        state_q     <= ST_ON;
                    end
                end
                ST_ON: begin
                    if (tick) begin
                        state_q <= ST_OFF;
                    end
                end
                // remaining counts blinks still to show including the current one,
                // so it never goes below 1 before the gap starts.
                ST_OFF: begin
                    if (tick) begin
                        if (remaining_q > 4'd1) begin
                            remaining_q <= remaining_q - 4'd1;
                            state_q     <= ST_ON;
                        end else begin
                            gap_cnt_q <= GAP_LOAD;
                            state_q   <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (tick) begin
                        if (gap_cnt_q == 4'd1) begin
                            gap_cnt_q   <= 4'd0;
                            remaining_q <= 4'd0;
                            state_q     <= ST_IDLE;
                        end else begin
                            gap_cnt_q <= gap_cnt_q - 4'd1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign code_ready_out = (state_q == ST_IDLE);
    assign busy_out       = (state_q != ST_IDLE);
    assign led_out        = led_q;

endmodule

// File: tb/tb_led_status_blinker.sv
// Purpose : randomized scoreboard bench for led_status_blinker.
// Latency : driver pushes the expected blink pattern per accepted code; a negedge monitor measures the LED and busy.
// Backpressure: codes offered while busy are expected to be dropped; any extra sequence is flagged.
module tb_led_status_blinker;

    localparam int G = 4;

    logic       clk_in        = 1'b0;
    logic       reset_in      = 1'b1;
    logic       beat_in       = 1'b0;
    logic [3:0] code_in       = 4'd0;
    logic       code_valid_in = 1'b0;
    logic       code_ready_out;
    logic       busy_out;
    logic       led_out;

    always #5 clk_in = ~clk_in;

    led_status_blinker #(
        .GAP_BEATS (G),
        .PWM_DUTY  (16)
    ) dut (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .beat_in        (beat_in),
        .code_in        (code_in),
        .code_valid_in  (code_valid_in),
        .code_ready_out (code_ready_out),
        .busy_out       (busy_out),
        .led_out        (led_out)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Expected sequence: n blinks, each lit p cycles and dark p cycles,
    // then G*p dark cycles; busy for (2n+G)*p cycles in total.
    typedef struct {
        int n;
        int p;
    } txn_t;

    txn_t exp_q[$];
    bit   mon_en  = 1'b0;
    int   P       = 10;
    int   bcnt    = 0;
    bit   toggled = 1'b0;

    // One clock: drive inputs 1 time unit after the rising edge; the heartbeat
    // toggles every P cycles.
    task automatic cyc();
        @(posedge clk_in);
        #1;
        code_valid_in = 1'b0;
        bcnt++;
        toggled = 1'b0;
        if (bcnt >= P) begin
            bcnt    = 0;
            beat_in = ~beat_in;
            toggled = 1'b1;
        end
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (!code_ready_out && guard < 2000) begin
            cyc();
            guard++;
        end
        if (!code_ready_out) check("ready_timeout", 0, 1);
    endtask

    // junk: 0 none, 1 offer code 5 every busy cycle, 2 random offers while busy
    task automatic run_code(input int n, input int p, input int junk);
        int guard = 0;
        wait_ready();
        P    = p;
        bcnt = 0;
        do begin
            cyc();
            guard++;
        end while (!toggled && guard < 100);
        // Offer the code on a tick cycle so the first blink is a full interval.
        code_in       = n[3:0];
        code_valid_in = 1'b1;
        if (n != 0) exp_q.push_back('{n, p});
        for (int i = 0; i < (2 * n + G) * p + 3; i++) begin
            cyc();
            if (busy_out) begin
                if (junk == 1) begin
                    code_valid_in = 1'b1;
                    code_in       = 4'd5;
                end else if (junk == 2 && $urandom_range(0, 7) == 0) begin
                    code_valid_in = 1'b1;
                    code_in       = 4'($urandom_range(1, 15));
                end
            end
            if (n == 0 && i == 0) begin
                check("zero_ready", int'(code_ready_out), 1);
                check("zero_busy", int'(busy_out), 0);
            end
        end
        check("end_ready", int'(code_ready_out), 1);
        check("end_led", int'(led_out), 0);
    endtask

    // Monitor: measures lit/dark run lengths and busy length against the scoreboard.
    txn_t cur;
    bit   in_seq    = 1'b0;
    bit   prev_busy = 1'b0;
    bit   prev_led  = 1'b0;
    int   busy_len  = 0;
    int   pulses    = 0;
    int   hi_len    = 0;
    int   lo_len    = 0;

    initial begin
        forever begin
            @(negedge clk_in);
            if (!mon_en) begin
                in_seq = 1'b0;
            end else begin
                if (busy_out && !prev_busy) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_seq", 1, 0);
                        in_seq = 1'b0;
                    end else begin
                        cur      = exp_q.pop_front();
                        in_seq   = 1'b1;
                        busy_len = 0;
                        pulses   = 0;
                    end
                end
                if (in_seq) begin
                    if (led_out && !prev_led && pulses > 0) check("dark_len", lo_len, cur.p);
                    if (!led_out && prev_led) begin
                        check("lit_len", hi_len, cur.p);
                        pulses++;
                    end
                    if (busy_out) busy_len++;
                    if (!busy_out && prev_busy) begin
                        check("busy_len", busy_len, (2 * cur.n + G) * cur.p);
                        check("blinks", pulses, cur.n);
                        in_seq = 1'b0;
                    end
                end else if (led_out && !prev_led) begin
                    check("stray_led", 1, 0);
                end
            end
            if (led_out && !prev_led) hi_len = 0;
            if (!led_out && prev_led) lo_len = 0;
            if (led_out) hi_len++;
            else lo_len++;
            prev_busy = busy_out;
            prev_led  = led_out;
        end
    end

    initial begin
        int bad;
        // Reset asserted before any clock edge.
        #1 reset_in = 1'b0;
        #2;
        check("rst_led", int'(led_out), 0);
        check("rst_ready", int'(code_ready_out), 1);
        check("rst_busy", int'(busy_out), 0);
        repeat (3) cyc();
        reset_in = 1'b1;
        cyc();
        check("post_rst_ready", int'(code_ready_out), 1);
        check("post_rst_led", int'(led_out), 0);
        mon_en = 1'b1;

        run_code(3, 10, 0);
        run_code(3, 10, 1);
        run_code(0, 7, 0);
        run_code(15, 3, 0);
        run_code(1, 5, 0);

        // Reset pulse while lit with code 7: sequence must abort with no later blinks.
        mon_en = 1'b0;
        wait_ready();
        P    = 8;
        bcnt = 0;
        begin
            int guard = 0;
            do begin
                cyc();
                guard++;
            end while (!toggled && guard < 100);
        end
        code_in       = 4'd7;
        code_valid_in = 1'b1;
        repeat (3) cyc();
        check("pre_abort_led", int'(led_out), 1);
        reset_in = 1'b0;
        #1;
        check("abort_led", int'(led_out), 0);
        check("abort_ready", int'(code_ready_out), 1);
        check("abort_busy", int'(busy_out), 0);
        cyc();
        reset_in = 1'b1;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            cyc();
            if (led_out || busy_out) bad++;
        end
        check("no_blink_after_reset", bad, 0);
        mon_en = 1'b1;
        cyc();

        for (int k = 0; k < 12; k++) begin
            run_code($urandom_range(0, 15), $urandom_range(2, 9), 2);
        end

        repeat (20) cyc();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_status_blinker.md
LED_STATUS_BLINKER -- requirements
Module: led_status_blinker

Interface
REQ-001 Parameter GAP_BEATS, default 4: beat ticks of dark gap after a code's last blink; legal range 1..15.
REQ-002 Parameter PWM_DUTY, default 8: PWM on-slots out of 16 while lit; legal range 1..16; used only under LED_PWM_EN.
REQ-003 clk_in  input  1  system clock; all logic is on its rising edge.
REQ-004 reset_in  input  1  asynchronous, active-low reset.
REQ-005 beat_in  input  1  heartbeat square wave (toggles every half second), synchronous to clk_in.
REQ-006 code_in  input  4  status code: number of blinks to display (0..15).
REQ-007 code_valid_in  input  1  code_in is valid this cycle.
REQ-008 code_ready_out  output  1  block can accept a code.
REQ-009 busy_out  output  1  a blink sequence (blinks or gap) is in progress.
REQ-010 led_out  output  1  LED drive, active-high.

Function
REQ-011 Block SHALL register beat_in into beat_q; tick = beat_in XOR beat_q, so every beat_in edge, rising or falling, is one tick.
REQ-012 FSM states SHALL be IDLE, ON, OFF and GAP.
REQ-013 code_ready_out SHALL be 1 exactly when state is IDLE; busy_out SHALL be 1 exactly when state is not IDLE.
REQ-014 Handshake: a transfer occurs on a cycle where code_valid_in and code_ready_out are both 1; code_valid_in while not ready SHALL be ignored, not queued.
REQ-015 On a transfer with code_in != 0, block SHALL latch remaining = code_in and enter ON on the next edge; led is lit from that cycle.
REQ-016 On a transfer with code_in = 0, block SHALL remain in IDLE with no blink and ready held at 1.
REQ-017 A tick on the transfer cycle SHALL be ignored; ticks in IDLE SHALL be ignored.
REQ-018 ON: on a tick, go to OFF.
REQ-019 OFF: on a tick, if remaining > 1, decrement remaining and go to ON; otherwise load gap_cnt = GAP_BEATS and go to GAP.
REQ-020 GAP: on each tick, decrement gap_cnt; when the tick arrives with gap_cnt = 1, go to IDLE.
REQ-021 Each blink SHALL be lit for exactly one tick interval and dark for one tick interval. The final gap SHALL be dark for GAP_BEATS tick intervals.
REQ-022 led_on SHALL be 1 exactly in state ON. led_out SHALL be registered, lagging led_on by one cycle.
REQ-023 Counters SHALL never wrap: remaining stays in 1..15 outside IDLE, and gap_cnt stays in 1..GAP_BEATS in GAP.

Reset
REQ-024 While reset_in = 0, regardless of clock, the block SHALL set the following values:
- state = IDLE
- beat_q = 0
- remaining = 0
- gap_cnt = 0
- PWM counter = 0
- led_out = 0
- code_ready_out = 1
- busy_out = 0
REQ-025 Reset mid-sequence SHALL abort the sequence immediately, with no partial blink after release.
REQ-026 The first cycle after release SHALL use beat_q = 0. If beat_in = 1 then, a tick fires but is ignored in IDLE.

Configuration
REQ-027 Macro LED_PWM_EN defined: a 4-bit free-running counter pwm_cnt increments every clk_in. The registered LED SHALL then be led_on AND (pwm_cnt < PWM_DUTY); PWM_DUTY = 16 gives fully on.
REQ-028 Macro LED_PWM_EN undefined: no PWM counter; the registered LED SHALL equal led_on. PWM_DUTY is unused.

Verification
REQ-029 Code 3, beat_in toggling every 10 cycles, GAP_BEATS 4 -> led_out shows exactly 3 lit pulses of 10 cycles, separated by 10-cycle darks. A 40-cycle dark gap follows, then ready returns to 1.
REQ-030 code_valid_in with code 5 during busy -> ignored. Sequence continues for the original code, and no extra blinks appear.
REQ-031 code_valid_in with code 0 -> ready stays 1, busy stays 0, led_out stays 0.
REQ-032 Code 15 -> 15 blinks then gap. remaining never underflows, and no wrap to a further blink occurs.
REQ-033 reset_in pulsed low for 1 cycle while in ON with code 7 -> led_out = 0 and ready = 1 immediately. No blinks occur after release until a new code is accepted.
REQ-034 LED_PWM_EN, PWM_DUTY 4, code 1 -> during ON, led_out is high for 4 of every 16 cycles. Without the macro -> led_out is steadily high for the whole ON interval.
